calc_op_sequencer: RTL and testbench

Sequences the calculator datapath. It turns debounced button levels into complete operations against the stack/queue memory and the ALU. Enter pushes the switch value. An op button pops two operands, drives the ALU, and pushes the result back. It sits between the debouncers and the Memory_Controller/ALU pair, and supplies the value shown on the seven-segment display.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/btn_edge.sv | 21 ++
 rtl/calc_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
package calc_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_SW,
    POP1,
    POP2,
    EXEC,
    CAPTURE,
    PUSH_RES,
    RESTORE
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_FULL  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: the previous level is registered, the event pulse is
// high for the single cycle in which a bit first reads 1.
module btn_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] lvl_q;

  always_ff @(posedge clk) begin
    if (!rst) lvl_q <= '0;
    else      lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: turns button events into push / pop-pop-ALU-push
// transactions against the stack/queue memory. Optional build macro: OVF_TRAP_EN.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SW_W   = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        btn_db,
  input  logic [SW_W-1:0]   switches,
  input  logic              stack_queue,
  input  logic              mem_empty,
  input  logic              mem_full,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_ovf,
  output logic              busy,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] disp_value
);

  state_t            state, state_nxt;
  logic [4:0]        btn_rise;
  logic              enter_evt, op_evt;
  logic              mode_stack;
  logic              pop2_go;
  logic [DATA_W-1:0] op1, op2;
  logic [DATA_W-1:0] sw_ext;

  btn_edge #(.W(5)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  (btn_db),
    .rise (btn_rise)
  );

  assign enter_evt = btn_rise[0];
  assign op_evt    = |btn_rise[4:1];
  assign sw_ext    = {{(DATA_W-SW_W){1'b0}}, switches};

`ifndef OVF_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // POP2 spends its first cycle looking at mem_empty; pop2_go marks that the
  // second pop has been committed so the request cannot drop mid-handshake.
  always_comb begin
    state_nxt = state;
    mem_push  = 1'b0;
    mem_pop   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (enter_evt) begin
          if (!mem_full) state_nxt = PUSH_SW;
        end else if (op_evt && !mem_empty) begin
          state_nxt = POP1;
        end
      end
      PUSH_SW: begin
        mem_push = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      POP1: begin
        mem_pop = 1'b1;
        if (mem_ack) state_nxt = POP2;
      end
      POP2: begin
        if (!pop2_go) begin
          if (mem_empty) state_nxt = RESTORE;
        end else begin
          mem_pop = 1'b1;
          if (mem_ack) state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = CAPTURE;
      CAPTURE: begin
`ifdef OVF_TRAP_EN
        state_nxt = alu_ovf ? IDLE : PUSH_RES;
`else
        state_nxt = PUSH_RES;
`endif
      end
      PUSH_RES: begin
        mem_push = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      RESTORE: begin
        mem_push = 1'b1;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_wdata doubles as the result register: CAPTURE loads alu_y straight into it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      disp_value <= '0;
      mem_wdata  <= '0;
      err_code   <= ERR_NONE;
      mode_stack <= 1'b0;
      pop2_go    <= 1'b0;
    end else begin
      pop2_go <= (state == POP2) && (pop2_go || !mem_empty);
      case (state)
        IDLE: begin
          if (enter_evt) begin
            if (mem_full) begin
              err_code <= ERR_FULL;
            end else begin
              err_code   <= ERR_NONE;
              mode_stack <= stack_queue;
              mem_wdata  <= sw_ext;
            end
          end else if (op_evt) begin
            if (mem_empty) begin
              err_code <= ERR_UNDER;
            end else begin
              err_code   <= ERR_NONE;
              mode_stack <= stack_queue;
              alu_op     <= btn_db[OP_W:1];
            end
          end
        end
        PUSH_SW, PUSH_RES: begin
          if (mem_ack) disp_value <= mem_wdata;
        end
        POP2: begin
          if (!pop2_go && mem_empty) mem_wdata <= op1;
        end
        EXEC: begin
          // Stack: the deeper word (second pop) is A. Queue: the older word is A.
          if (mode_stack) begin
            alu_a <= op2;
            alu_b <= op1;
          end else begin
            alu_a <= op1;
            alu_b <= op2;
          end
        end
        CAPTURE: begin
`ifdef OVF_TRAP_EN
          if (alu_ovf) err_code  <= ERR_OVF;
          else         mem_wdata <= alu_y;
`else
          mem_wdata <= alu_y;
`endif
        end
        RESTORE: begin
          if (mem_ack) err_code <= ERR_UNDER;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == POP1 && mem_ack)            op1 <= mem_rdata;
    if (state == POP2 && pop2_go && mem_ack) op2 <= mem_rdata;
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: memory responder, ALU model and a word-level
// reference model of the calculator stack/queue.
module tb_calc_op_sequencer;

  localparam int DW  = 32;
  localparam int CAP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    btn_db = '0;
  logic [15:0]   switches = '0;
  logic          stack_queue = 1'b1;
  logic          mem_empty, mem_full;
  logic          mem_push, mem_pop;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [3:0]    alu_op;
  logic          alu_ovf;
  logic          busy;
  logic [1:0]    err_code;
  logic [DW-1:0] disp_value;

  int ack_dly = 0;
  bit force_full = 0;
  bit ovf_force = 0;
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] ref_q[$];
  int pushes_done = 0, pops_done = 0, push_cyc = 0, req_cyc = 0;
  int both_hi = 0, req_drop = 0;
  int n_chk = 0, n_fail = 0;

  logic [DW-1:0] exp_disp, exp_a, exp_b;
  logic [1:0]    exp_err;
  logic [3:0]    exp_op;
  int            exp_bcyc;
  bit            exp_exec;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0100: return a & b;
      4'b1000: return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign alu_y   = alu_f(alu_op, alu_a, alu_b);
  assign alu_ovf = ovf_force;

  calc_op_sequencer #(.DATA_W(DW), .SW_W(16), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .btn_db(btn_db), .switches(switches), .stack_queue(stack_queue),
    .mem_empty(mem_empty), .mem_full(mem_full), .mem_push(mem_push), .mem_pop(mem_pop),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_ovf(alu_ovf),
    .busy(busy), .err_code(err_code), .disp_value(disp_value)
  );

  // Memory responder: acts 2 time units after each rising edge.
  initial begin
    int cnt;
    logic pv_push, pv_pop;
    cnt = 0; pv_push = 0; pv_pop = 0;
    mem_ack = 0; mem_rdata = '0; mem_empty = 1; mem_full = 0;
    forever begin
      @(posedge clk); #2;
      if (mem_push && mem_pop) both_hi++;
      if (rst && !mem_ack && ((pv_push && !mem_push) || (pv_pop && !mem_pop))) req_drop++;
      if (mem_push) push_cyc++;
      if (mem_push || mem_pop) req_cyc++;
      pv_push = mem_push;
      pv_pop  = mem_pop;
      mem_ack = 0;
      if (rst && (mem_push || mem_pop)) begin
        if (cnt >= ack_dly) begin
          if (mem_push) begin
            mem_q.push_back(mem_wdata);
            pushes_done++;
          end else begin
            if (mem_q.size() == 0) mem_rdata = '0;
            else if (stack_queue)  mem_rdata = mem_q.pop_back();
            else                   mem_rdata = mem_q.pop_front();
            pops_done++;
          end
          mem_ack = 1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      mem_empty = (mem_q.size() == 0);
      mem_full  = force_full || (mem_q.size() >= CAP);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mem_same();
    if (mem_q.size() != ref_q.size()) return 0;
    foreach (mem_q[i]) if (mem_q[i] !== ref_q[i]) return 0;
    return 1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_push"}, 32'(mem_push), 0);
    chk({tag, "_pop"}, 32'(mem_pop), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err_code), 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, 32'(alu_op), 0);
    chk({tag, "_disp"}, disp_value, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  // Reference model: word-level calculator semantics.
  task automatic ref_enter(input logic [15:0] sw);
    exp_exec = 0;
    if (force_full || ref_q.size() >= CAP) begin
      exp_err = 2'b10; exp_bcyc = 0;
    end else begin
      ref_q.push_back({16'h0, sw});
      exp_disp = {16'h0, sw}; exp_err = 2'b00; exp_bcyc = ack_dly + 1;
    end
  endtask

  task automatic ref_op(input logic [4:0] b);
    logic [DW-1:0] x, y;
    exp_exec = 0;
    if (ref_q.size() == 0) begin
      exp_err = 2'b01; exp_bcyc = 0;
    end else if (ref_q.size() == 1) begin
      exp_err = 2'b01; exp_bcyc = 2 * ack_dly + 3;
    end else begin
      if (stack_queue) begin
        y = ref_q.pop_back(); x = ref_q.pop_back();
      end else begin
        x = ref_q.pop_front(); y = ref_q.pop_front();
      end
      exp_a = x; exp_b = y; exp_op = b[4:1];
      exp_disp = alu_f(b[4:1], x, y);
      ref_q.push_back(exp_disp);
      exp_err = 2'b00; exp_bcyc = 3 * ack_dly + 6; exp_exec = 1;
    end
  endtask

  task automatic press(input string tag, input logic [4:0] b, input logic [15:0] sw,
                       output int bcyc);
    bit seen, tmo;
    @(negedge clk); switches = sw; btn_db = b;
    @(negedge clk); btn_db = '0;
    bcyc = 0; seen = 0; tmo = 1;
    for (int n = 0; n < 200; n++) begin
      if (busy) begin
        bcyc++; seen = 1;
      end else if (seen || n >= 3) begin
        tmo = 0;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_timeout"}, 32'(tmo), 0);
  endtask

  task automatic check_after(input string tag, input int bcyc);
    chk({tag, "_err"}, 32'(err_code), 32'(exp_err));
    chk({tag, "_disp"}, disp_value, exp_disp);
    chk({tag, "_busycyc"}, bcyc, exp_bcyc);
    chk({tag, "_memsize"}, mem_q.size(), ref_q.size());
    chk({tag, "_memdata"}, 32'(mem_same()), 1);
    if (exp_exec) begin
      chk({tag, "_alu_a"}, alu_a, exp_a);
      chk({tag, "_alu_b"}, alu_b, exp_b);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'(exp_op));
    end
  endtask

  task automatic run_enter(input string tag, input logic [15:0] sw);
    int bc;
    ref_enter(sw);
    press(tag, 5'b00001, sw, bc);
    check_after(tag, bc);
  endtask

  task automatic run_op(input string tag, input logic [4:0] b);
    int bc;
    ref_op(b);
    press(tag, b, switches, bc);
    check_after(tag, bc);
  endtask

  initial begin
    int p0, u0, c0, bc;
    bit hit;
    exp_disp = '0; exp_a = '0; exp_b = '0; exp_err = '0; exp_op = '0;
    exp_bcyc = 0; exp_exec = 0;

    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1;

    stack_queue = 1;
    run_enter("stk_e5", 16'd5);
    run_enter("stk_e3", 16'd3);
    run_op("stk_add", 5'b00010);
    chk("stk_a_const", alu_a, 5);
    chk("stk_b_const", alu_b, 3);
    chk("stk_disp_const", disp_value, 8);
    chk("stk_words", mem_q.size(), 1);

    @(negedge clk); mem_q.delete(); ref_q.delete(); stack_queue = 0;
    run_enter("q_e10", 16'd10);
    run_enter("q_e4", 16'd4);
    run_op("q_sub", 5'b00100);
    chk("q_a_const", alu_a, 10);
    chk("q_b_const", alu_b, 4);

    @(negedge clk); mem_q.delete(); ref_q.delete(); stack_queue = 1;
    run_enter("uf_e7", 16'd7);
    p0 = pops_done; u0 = pushes_done;
    run_op("uf_op", 5'b00010);
    chk("uf_pops", pops_done - p0, 1);
    chk("uf_restore_push", pushes_done - u0, 1);
    chk("uf_word", mem_q.size() > 0 ? mem_q[0] : 32'hdead, 7);

    @(negedge clk); mem_q.delete(); ref_q.delete();
    c0 = req_cyc;
    run_op("empty_op", 5'b01000);
    chk("empty_noreq", req_cyc - c0, 0);

    @(negedge clk); force_full = 1;
    c0 = push_cyc;
    run_enter("full_e", 16'h1234);
    chk("full_nopush", push_cyc - c0, 0);
    @(negedge clk); force_full = 0;
    run_enter("full_clear", 16'h0042);

    // Op pressed while a slow push is outstanding must be dropped.
    @(negedge clk); mem_q.delete(); ref_q.delete(); ack_dly = 5;
    p0 = pops_done;
    ref_enter(16'h0055);
    @(negedge clk); switches = 16'h0055; btn_db = 5'b00001;
    @(negedge clk); btn_db = '0;
    chk("busy_in_push", 32'(busy), 1);
    @(negedge clk); btn_db = 5'b00010;
    @(negedge clk); btn_db = '0;
    hit = 0;
    for (int n = 0; n < 50; n++) begin
      if (!busy) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("busy_wait", 32'(hit), 1);
    repeat (3) @(negedge clk);
    chk("busy_op_dropped", pops_done - p0, 0);
    chk("busy_stays_idle", 32'(busy), 0);
    chk("busy_memdata", 32'(mem_same()), 1);
    chk("busy_disp", disp_value, 32'h55);

    ack_dly = 0;
    p0 = pops_done;
    ref_enter(16'h0abc);
    press("simul", 5'b00011, 16'h0abc, bc);
    check_after("simul", bc);
    chk("simul_nopop", pops_done - p0, 0);

    // Reset asserted while the second pop is outstanding.
    @(negedge clk); mem_q.delete(); ref_q.delete();
    mem_q.push_back(32'd11); mem_q.push_back(32'd22);
    ack_dly = 3; stack_queue = 1;
    p0 = pops_done;
    @(negedge clk); btn_db = 5'b00010;
    @(negedge clk); btn_db = '0;
    hit = 0;
    for (int n = 0; n < 60; n++) begin
      if (pops_done == p0 + 1 && mem_pop) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("rst_pop2_reached", 32'(hit), 1);
    rst = 0;
    @(negedge clk);
    chk_idle("midrst");
    chk("midrst_mem", mem_q.size(), 1);
    rst = 1; ack_dly = 0;
    mem_q.delete(); ref_q.delete();
    exp_disp = '0;

`ifdef OVF_TRAP_EN
    run_enter("ovf_e1", 16'd1);
    run_enter("ovf_e2", 16'd2);
    @(negedge clk); ovf_force = 1;
    u0 = pushes_done;
    press("ovf_op", 5'b00010, 16'd0, bc);
    chk("ovf_err", 32'(err_code), 3);
    chk("ovf_nopush", pushes_done - u0, 0);
    chk("ovf_consumed", mem_q.size(), 0);
    chk("ovf_disp", disp_value, 2);
    ovf_force = 0;
    mem_q.delete(); ref_q.delete();
    exp_disp = disp_value;
`endif

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ack_dly = $urandom_range(0, 2);
      stack_queue = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) run_enter("rnd_enter", 16'($urandom));
      else run_op("rnd_op", {4'($urandom_range(1, 15)), 1'b0});
    end

    chk("never_both_high", both_hi, 0);
    chk("req_held_to_ack", req_drop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
